// File: rtl/if_neuron_array.sv
// if_neuron_array
//   Parametrised array of integrate-and-fire neurons. DEPTH words of neuron
//   state, each word holding LANES neurons packed LSB-first as
//   {en, cnt, thr, mem}. Events run through an IDLE->RD->UPD->WR pass
//   (one event per four cycles); a spike report is issued on WR for every event.
//
//   Optional build macro: NEUR_LEAK_EN -- time-step events apply
//   mem <= mem - (mem >>> LEAK_SHIFT) on enabled lanes. Without it a time
//   step writes the word back unchanged.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   EVT_VALID/EVT_READY   event handshake (ready only in IDLE with no PROG_* request)
//   EVT_TYPE              00 synaptic, 01 time step, 10 time reference, 11 reserved
//   EVT_ADDR, EVT_WEIGHTS target word, signed weight per lane (lane i at [i*W_W +: W_W])
//   SPIKE_VALID/ADDR/VEC  one-cycle spike report during WR
//   PROG_READY            programming port usable (IDLE, not in reset)
//   PROG_WE/PROG_RD       direct word write / read (write wins if both)
//   PROG_ADDR, PROG_DATA  programming address and write data
//   RD_VALID, RD_DATA     read data, one cycle after PROG_RD
//   BUSY                  FSM not in IDLE
module if_neuron_array #(
   parameter int unsigned LANES      = 4,
   parameter int unsigned MEM_W      = 12,
   parameter int unsigned CNT_W      = 7,
   parameter int unsigned W_W        = 8,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned LEAK_SHIFT = 4
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 EVT_VALID,
   output logic                                 EVT_READY,
   input  logic [1:0]                           EVT_TYPE,
   input  logic [ADDR_W-1:0]                    EVT_ADDR,
   input  logic [LANES*W_W-1:0]                 EVT_WEIGHTS,
   output logic                                 SPIKE_VALID,
   output logic [ADDR_W-1:0]                    SPIKE_ADDR,
   output logic [LANES-1:0]                     SPIKE_VEC,
   output logic                                 PROG_READY,
   input  logic                                 PROG_WE,
   input  logic                                 PROG_RD,
   input  logic [ADDR_W-1:0]                    PROG_ADDR,
   input  logic [LANES*(1+CNT_W+2*MEM_W)-1:0]   PROG_DATA,
   output logic                                 RD_VALID,
   output logic [LANES*(1+CNT_W+2*MEM_W)-1:0]   RD_DATA,
   output logic                                 BUSY
);

   localparam int unsigned LW     = 1 + CNT_W + 2*MEM_W;
   localparam int unsigned WORD_W = LANES * LW;

   localparam logic [MEM_W-1:0] MEM_MAX = {1'b0, {(MEM_W-1){1'b1}}};
   localparam logic [MEM_W-1:0] MEM_MIN = {1'b1, {(MEM_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (W_W > MEM_W || ADDR_W < $clog2(DEPTH) || LEAK_SHIFT >= MEM_W) begin : g_param_check
      $error("if_neuron_array: invalid parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_RD, S_UPD, S_WR} state_t;
   typedef enum logic [1:0] {EV_SYN = 2'b00, EV_STEP = 2'b01, EV_TREF = 2'b10, EV_RSVD = 2'b11} evt_t;

   state_t state, state_nxt;

   logic [WORD_W-1:0]     mem [DEPTH];
   logic [ADDR_W-1:0]     addr_q;
   evt_t                  type_q;
   logic [LANES*W_W-1:0]  w_q;
   logic [WORD_W-1:0]     rd_word;
   logic [WORD_W-1:0]     upd_word, upd_q;
   logic [LANES-1:0]      upd_spk, spk_q;

   logic evt_fire, prog_we_ok, prog_rd_ok;

   assign evt_fire   = EVT_VALID && EVT_READY;
   assign prog_we_ok = PROG_WE && PROG_READY;
   assign prog_rd_ok = PROG_RD && !PROG_WE && PROG_READY;

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (evt_fire) state_nxt = S_RD;
         S_RD:    state_nxt = S_UPD;
         S_UPD:   state_nxt = S_WR;
         S_WR:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // outputs; everything is held low while RST is asserted
   always_comb begin
      EVT_READY   = 1'b0;
      PROG_READY  = 1'b0;
      BUSY        = 1'b0;
      SPIKE_VALID = 1'b0;
      SPIKE_ADDR  = '0;
      SPIKE_VEC   = '0;
      if (!RST) begin
         BUSY = (state != S_IDLE);
         if (state == S_IDLE) begin
            PROG_READY = 1'b1;
            EVT_READY  = !PROG_WE && !PROG_RD;
         end
         if (state == S_WR) begin
            SPIKE_VALID = 1'b1;
            SPIKE_ADDR  = addr_q;
            SPIKE_VEC   = spk_q;
         end
      end
   end

   // neuron memory (not reset); write-back is suppressed if RST lands on WR
   always_ff @(posedge CLK) begin
      if (prog_we_ok)
         mem[PROG_ADDR] <= PROG_DATA;
      else if (state == S_WR && !RST)
         mem[addr_q] <= upd_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         RD_VALID <= 1'b0;
         RD_DATA  <= '0;
      end else begin
         RD_VALID <= prog_rd_ok;
         if (prog_rd_ok) RD_DATA <= mem[PROG_ADDR];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q  <= '0;
         type_q  <= EV_SYN;
         w_q     <= '0;
         rd_word <= '0;
         upd_q   <= '0;
         spk_q   <= '0;
      end else begin
         if (evt_fire) begin
            addr_q <= EVT_ADDR;
            type_q <= evt_t'(EVT_TYPE);
            w_q    <= EVT_WEIGHTS;
         end
         if (state == S_RD) rd_word <= mem[addr_q];
         if (state == S_UPD) begin
            upd_q <= upd_word;
            spk_q <= upd_spk;
         end
      end
   end

   // per-lane update
   logic              lane_en;
   logic [CNT_W-1:0]  lane_cnt, nxt_cnt;
   logic [MEM_W-1:0]  lane_thr, lane_mem, nxt_mem, sat;
   logic [W_W-1:0]    wt;
   logic [MEM_W:0]    sum;

   always_comb begin
      upd_word = rd_word;
      upd_spk  = '0;
      lane_en  = 1'b0;
      lane_cnt = '0;
      lane_thr = '0;
      lane_mem = '0;
      nxt_cnt  = '0;
      nxt_mem  = '0;
      sat      = '0;
      wt       = '0;
      sum      = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         {lane_en, lane_cnt, lane_thr, lane_mem} = rd_word[i*LW +: LW];
         wt  = w_q[i*W_W +: W_W];
         // one guard bit: overflow shows as a mismatch of the top two bits
         sum = {lane_mem[MEM_W-1], lane_mem} + {{(MEM_W+1-W_W){wt[W_W-1]}}, wt};
         if (sum[MEM_W] != sum[MEM_W-1]) sat = sum[MEM_W] ? MEM_MIN : MEM_MAX;
         else                            sat = sum[MEM_W-1:0];
         nxt_mem = lane_mem;
         nxt_cnt = lane_cnt;
         if (lane_en) begin
            case (type_q)
               EV_SYN: begin
                  // thr is unsigned, so a non-negative sum compares as unsigned
                  if (!sat[MEM_W-1] && sat >= lane_thr) begin
                     nxt_mem    = '0;
                     upd_spk[i] = 1'b1;
                     if (lane_cnt != CNT_MAX) nxt_cnt = lane_cnt + 1'b1;
                  end else begin
                     nxt_mem = sat;
                  end
               end
               EV_STEP: begin
`ifdef NEUR_LEAK_EN
                  nxt_mem = lane_mem - $unsigned($signed(lane_mem) >>> LEAK_SHIFT);
`endif
               end
               EV_TREF: begin
                  nxt_mem = '0;
                  nxt_cnt = '0;
               end
               default: ;
            endcase
         end
         upd_word[i*LW +: LW] = {lane_en, nxt_cnt, lane_thr, nxt_mem};
      end
   end

endmodule

// File: tb/tb_if_neuron_array.sv
// Scoreboard bench for if_neuron_array: stimulus pushes expected spike
// reports and read-back words; a monitor pops and compares them.
module tb_if_neuron_array;

   localparam int LANES = 4, MEM_W = 12, CNT_W = 7, W_W = 8;
   localparam int DEPTH = 64, ADDR_W = 6, LEAK_SHIFT = 4;
   localparam int LW = 1 + CNT_W + 2*MEM_W;
   localparam int WORD_W = LANES * LW;
   localparam int WV = LANES * W_W;
   localparam int MEM_HI = 2**(MEM_W-1) - 1;
   localparam int MEM_LO = -(2**(MEM_W-1));
   localparam int CNT_MAX = 2**CNT_W - 1;

   logic                CLK = 1'b0;
   logic                RST, EVT_VALID, EVT_READY;
   logic [1:0]          EVT_TYPE;
   logic [ADDR_W-1:0]   EVT_ADDR;
   logic [WV-1:0]       EVT_WEIGHTS;
   logic                SPIKE_VALID;
   logic [ADDR_W-1:0]   SPIKE_ADDR;
   logic [LANES-1:0]    SPIKE_VEC;
   logic                PROG_READY, PROG_WE, PROG_RD;
   logic [ADDR_W-1:0]   PROG_ADDR;
   logic [WORD_W-1:0]   PROG_DATA;
   logic                RD_VALID;
   logic [WORD_W-1:0]   RD_DATA;
   logic                BUSY;

   if_neuron_array #(
      .LANES(LANES), .MEM_W(MEM_W), .CNT_W(CNT_W), .W_W(W_W),
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEAK_SHIFT(LEAK_SHIFT)
   ) dut (
      .CLK(CLK), .RST(RST),
      .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_TYPE(EVT_TYPE),
      .EVT_ADDR(EVT_ADDR), .EVT_WEIGHTS(EVT_WEIGHTS),
      .SPIKE_VALID(SPIKE_VALID), .SPIKE_ADDR(SPIKE_ADDR), .SPIKE_VEC(SPIKE_VEC),
      .PROG_READY(PROG_READY), .PROG_WE(PROG_WE), .PROG_RD(PROG_RD),
      .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
      .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // behavioural neuron state, plain integers
   int m_en  [DEPTH][LANES];
   int m_cnt [DEPTH][LANES];
   int m_thr [DEPTH][LANES];
   int m_mem [DEPTH][LANES];

   typedef struct { logic [ADDR_W-1:0] addr; logic [LANES-1:0] vec; int due; } spk_t;
   typedef struct { logic [WORD_W-1:0] data; int due; } rd_t;
   spk_t spk_q[$];
   rd_t  rd_q[$];
   spk_t spk_e;
   rd_t  rd_e;

   task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=response", nm);
   endtask

   function automatic int sgn(input int v);
      return (v > MEM_HI) ? v - 2**MEM_W : v;
   endfunction

   function automatic void set_lane(input int a, input int i, input int en, input int cnt,
                                    input int thr, input int mv);
      m_en[a][i] = en; m_cnt[a][i] = cnt; m_thr[a][i] = thr; m_mem[a][i] = mv;
   endfunction

   function automatic logic [WORD_W-1:0] model_word(input int a);
      logic [WORD_W-1:0] w;
      logic [LW-1:0]     f;
      w = '0;
      for (int i = 0; i < LANES; i++) begin
         f = {m_en[a][i] != 0, CNT_W'(m_cnt[a][i]), MEM_W'(m_thr[a][i]), MEM_W'(m_mem[a][i])};
         w[i*LW +: LW] = f;
      end
      return w;
   endfunction

   function automatic logic [LANES-1:0] model_event(input int a, input int t, input logic [WV-1:0] wts);
      logic [LANES-1:0]     v;
      logic signed [W_W-1:0] w8;
      int s;
      v = '0;
      for (int i = 0; i < LANES; i++) begin
         if (m_en[a][i] == 0) continue;
         if (t == 0) begin
            w8 = wts[i*W_W +: W_W];
            s = m_mem[a][i] + int'(w8);
            if (s > MEM_HI) s = MEM_HI;
            if (s < MEM_LO) s = MEM_LO;
            if (s >= 0 && s >= m_thr[a][i]) begin
               v[i] = 1'b1;
               m_mem[a][i] = 0;
               if (m_cnt[a][i] < CNT_MAX) m_cnt[a][i]++;
            end else begin
               m_mem[a][i] = s;
            end
         end else if (t == 1) begin
`ifdef NEUR_LEAK_EN
            m_mem[a][i] = m_mem[a][i] - (m_mem[a][i] >>> LEAK_SHIFT);
`endif
         end else if (t == 2) begin
            m_mem[a][i] = 0;
            m_cnt[a][i] = 0;
         end
      end
      return v;
   endfunction

   // all driver tasks start and end at (or just after) a falling edge
   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (PROG_READY) begin ok = 1; break; end
         @(negedge CLK);
      end
      if (!ok) fail_now("wait_idle");
   endtask

   task automatic prog_write(input int a);
      wait_idle();
      PROG_WE = 1'b1; PROG_ADDR = ADDR_W'(a); PROG_DATA = model_word(a);
      @(posedge CLK);
      @(negedge CLK);
      PROG_WE = 1'b0;
   endtask

   task automatic prog_read(input int a);
      rd_t r;
      wait_idle();
      PROG_RD = 1'b1; PROG_ADDR = ADDR_W'(a);
      r.data = model_word(a); r.due = cyc + 1;
      rd_q.push_back(r);
      @(posedge CLK);
      @(negedge CLK);
      PROG_RD = 1'b0;
   endtask

   task automatic send_evt(input int a, input int t, input logic [WV-1:0] wts, input bit use_model);
      bit   got;
      spk_t e;
      got = 0;
      EVT_VALID = 1'b1; EVT_TYPE = 2'(t); EVT_ADDR = ADDR_W'(a); EVT_WEIGHTS = wts;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (EVT_READY) begin got = 1; break; end
         @(negedge CLK);
      end
      if (got) begin
         if (use_model) begin
            e.addr = ADDR_W'(a); e.vec = model_event(a, t, wts); e.due = cyc + 3;
            spk_q.push_back(e);
         end
         @(posedge CLK);
         @(negedge CLK);
      end else begin
         fail_now("evt_handshake");
      end
      EVT_VALID = 1'b0; EVT_WEIGHTS = $urandom; EVT_TYPE = 2'($urandom_range(0, 3));
   endtask

   // monitor
   always @(negedge CLK) begin
      #2;
      if (SPIKE_VALID) begin
         if (spk_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spike_unexpected actual=addr%0d/vec%b required=no_spike", SPIKE_ADDR, SPIKE_VEC);
         end else begin
            spk_e = spk_q.pop_front();
            chk("spike_addr", WORD_W'(SPIKE_ADDR), WORD_W'(spk_e.addr));
            chk("spike_vec", WORD_W'(SPIKE_VEC), WORD_W'(spk_e.vec));
            chk("spike_cycle", WORD_W'(cyc), WORD_W'(spk_e.due));
         end
      end
      if (RD_VALID) begin
         if (rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_unexpected actual=%h required=no_read", RD_DATA);
         end else begin
            rd_e = rd_q.pop_front();
            chk("rd_data", RD_DATA, rd_e.data);
            chk("rd_cycle", WORD_W'(cyc), WORD_W'(rd_e.due));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int hc [4];
      int t, a;
      RST = 1'b1; EVT_VALID = 1'b0; EVT_TYPE = '0; EVT_ADDR = '0; EVT_WEIGHTS = '0;
      PROG_WE = 1'b0; PROG_RD = 1'b0; PROG_ADDR = '0; PROG_DATA = '0;

      // reset values
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_evt_ready", WORD_W'(EVT_READY), '0);
      chk("rst_prog_ready", WORD_W'(PROG_READY), '0);
      chk("rst_spike_valid", WORD_W'(SPIKE_VALID), '0);
      chk("rst_rd_valid", WORD_W'(RD_VALID), '0);
      chk("rst_busy", WORD_W'(BUSY), '0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("post_rst_evt_ready", WORD_W'(EVT_READY), WORD_W'(1));
      chk("post_rst_prog_ready", WORD_W'(PROG_READY), WORD_W'(1));
      chk("post_rst_rd_data", RD_DATA, '0);
      chk("post_rst_spike", WORD_W'({SPIKE_ADDR, SPIKE_VEC}), '0);

      // addr 3: four lanes {1,0,0xAAA,0xAA0}, weights {+20,+5,-1,0}
      for (int i = 0; i < LANES; i++) set_lane(3, i, 1, 0, 'hAAA, sgn('hAA0));
      prog_write(3);
      send_evt(3, 0, {8'd0, 8'hFF, 8'd5, 8'd20}, 1);
      chk("busy_in_rd", WORD_W'(BUSY), WORD_W'(1));
      prog_read(3);

      // saturation at the positive rail, with and without a reachable threshold
      set_lane(4, 0, 1, 0, 'h7FF, 'h7F0);
      set_lane(4, 1, 1, 0, 'hAAA, 'h7F0);
      set_lane(4, 2, 1, 0, 'h100, -2040);
      set_lane(4, 3, 0, 5, 'h010, 7);
      prog_write(4);
      send_evt(4, 0, {8'd127, 8'h80, 8'd127, 8'd127}, 1);
      prog_read(4);

      // counter saturation then time reference
      set_lane(6, 0, 1, CNT_MAX, 0, 0);
      set_lane(6, 1, 1, CNT_MAX - 1, 3, 2);
      set_lane(6, 2, 0, 9, 0, 100);
      set_lane(6, 3, 1, 1, 'h7FF, -5);
      prog_write(6);
      send_evt(6, 0, {8'd1, 8'd120, 8'd1, 8'd0}, 1);
      prog_read(6);
      send_evt(6, 2, $urandom, 1);
      prog_read(6);

      // reserved type and time step (leak only when built with it)
      set_lane(5, 0, 1, 2, 'h7FF, 'h100);
      set_lane(5, 1, 1, 3, 'h7FF, -16);
      set_lane(5, 2, 1, 4, 0, 0);
      set_lane(5, 3, 0, 5, 0, 'h123);
      prog_write(5);
      send_evt(5, 3, 32'h7F7F7F7F, 1);
      prog_read(5);
      send_evt(5, 1, 32'h7F7F7F7F, 1);
      prog_read(5);

      // EVT_VALID held: back-to-back accumulation on one address
      for (int i = 0; i < LANES; i++) set_lane(7, i, 1, 0, 1000, 0);
      prog_write(7);
      wait_idle();
      EVT_VALID = 1'b1; EVT_TYPE = 2'd0; EVT_ADDR = ADDR_W'(7); EVT_WEIGHTS = {8'd100, 8'd60, 8'd40, 8'd90};
      for (int n = 0; n < 4; n++) begin
         bit got;
         got = 0;
         for (int k = 0; k < 20; k++) begin
            #1;
            if (EVT_READY) begin got = 1; break; end
            @(negedge CLK);
         end
         if (!got) fail_now("hold_handshake");
         hc[n] = cyc;
         spk_e.addr = ADDR_W'(7); spk_e.vec = model_event(7, 0, EVT_WEIGHTS); spk_e.due = cyc + 3;
         spk_q.push_back(spk_e);
         @(posedge CLK);
         @(negedge CLK);
         EVT_WEIGHTS = {8'd100, 8'd60, 8'd40, 8'd90};
      end
      EVT_VALID = 1'b0;
      for (int n = 1; n < 4; n++) chk("hold_spacing", WORD_W'(hc[n] - hc[n-1]), WORD_W'(4));
      prog_read(7);

      // PROG_WE with EVT_VALID in IDLE: program first, event after
      wait_idle();
      for (int i = 0; i < LANES; i++) set_lane(8, i, 1, 0, 50, 10 * i);
      PROG_WE = 1'b1; PROG_ADDR = ADDR_W'(8); PROG_DATA = model_word(8);
      EVT_VALID = 1'b1; EVT_TYPE = 2'd0; EVT_ADDR = ADDR_W'(8); EVT_WEIGHTS = {8'd10, 8'd10, 8'd10, 8'd45};
      #1;
      chk("prog_blocks_evt", WORD_W'(EVT_READY), '0);
      @(posedge CLK);
      @(negedge CLK);
      PROG_WE = 1'b0;
      send_evt(8, 0, {8'd10, 8'd10, 8'd10, 8'd45}, 1);
      prog_read(8);

      // PROG_WE and PROG_RD together: write only
      wait_idle();
      for (int i = 0; i < LANES; i++) set_lane(9, i, i & 1, i, 7 * i, -3 * i);
      PROG_WE = 1'b1; PROG_RD = 1'b1; PROG_ADDR = ADDR_W'(9); PROG_DATA = model_word(9);
      @(posedge CLK);
      @(negedge CLK);
      PROG_WE = 1'b0; PROG_RD = 1'b0;
      #2;
      chk("we_rd_no_read", WORD_W'(RD_VALID), '0);
      prog_read(9);

      // reset during UPD aborts the event
      for (int i = 0; i < LANES; i++) set_lane(10, i, 1, 3, 0, 20);
      prog_write(10);
      send_evt(10, 0, {8'd5, 8'd5, 8'd5, 8'd5}, 0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("rst_mid_evt_ready", WORD_W'(EVT_READY), '0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("rst_mid_ready_after", WORD_W'(EVT_READY), WORD_W'(1));
      chk("rst_mid_busy", WORD_W'(BUSY), '0);
      prog_read(10);

      // randomized phase on words 16..31
      for (int w = 16; w < 32; w++) begin
         for (int i = 0; i < LANES; i++)
            set_lane(w, i, ($urandom_range(0, 4) != 0), $urandom_range(0, CNT_MAX),
                     $urandom_range(0, 700), int'($urandom_range(0, 1200)) - 600);
         prog_write(w);
      end
      for (int n = 0; n < 80; n++) begin
         t = $urandom_range(0, 9);
         t = (t < 7) ? 0 : t - 6;
         a = $urandom_range(16, 31);
         send_evt(a, t, $urandom, 1);
         if (n % 10 == 9) prog_read($urandom_range(16, 31));
      end
      for (int w = 16; w < 32; w++) prog_read(w);

      // drain
      for (int k = 0; k < 50; k++) begin
         if (spk_q.size() == 0 && rd_q.size() == 0) break;
         @(negedge CLK);
      end
      repeat (2) @(negedge CLK);
      chk("spike_queue_drained", WORD_W'(spk_q.size()), '0);
      chk("read_queue_drained", WORD_W'(rd_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
